// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: pointer/occupancy controller for a 2**ADDR_W-entry FIFO.
// Generates the storage strobes and addresses, the occupancy count, the status
// flags, and a registered record of the last accepted operation.
// Optional feature macro: FIFO_CTRL_ERR_FLAGS_EN adds err_clr and the sticky
// overflow/underflow outputs.
module fifo_ctrl_param #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned AF_TH  = 6,
  parameter int unsigned AE_TH  = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow,
`endif
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [1:0]        op_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RDWR  = 2'd3
  } op_t;

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(AE_TH);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count_q;
  op_t             state_q;

  // Status derived from registered pointers only; MSB is the wrap bit.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    wr_en      = wr_req && !fifo_full;
    rd_en      = rd_req && !fifo_empty;
  end

  // Addresses, count and threshold flags.
  always_comb begin
    wr_addr      = wr_ptr[ADDR_W-1:0];
    rd_addr      = rd_ptr[ADDR_W-1:0];
    count        = count_q;
    almost_full  = (count_q >= AF_LVL);
    almost_empty = (count_q <= AE_LVL);
    op_state     = state_q;
  end

  // Pointer and occupancy update; reset discards everything in one edge.
  always_ff @(posedge clock) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Last-cycle operation FSM: next state is purely the accepted strobe pair.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10:   state_q <= ST_WRITE;
        2'b01:   state_q <= ST_READ;
        2'b11:   state_q <= ST_RDWR;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  // Sticky error flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req && fifo_full) overflow <= 1'b1;
      else if (err_clr)        overflow <= 1'b0;
      if (rd_req && fifo_empty) underflow <= 1'b1;
      else if (err_clr)         underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Table-driven bench for fifo_ctrl_param at ADDR_W=3, AF_TH=6, AE_TH=2.
module tb_fifo_ctrl_param;

  localparam int OP_IDLE  = 0;
  localparam int OP_WRITE = 1;
  localparam int OP_READ  = 2;
  localparam int OP_RDWR  = 3;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic       wr_en, rd_en;
  logic [2:0] wr_addr, rd_addr;
  logic [3:0] count;
  logic       fifo_full, fifo_empty, almost_full, almost_empty;
  logic [1:0] op_state;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic       err_clr = 1'b0;
  logic       overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;

  fifo_ctrl_param #(.ADDR_W(3), .AF_TH(6), .AE_TH(2)) dut (
    .clock        (clock),
    .rst          (rst),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .op_state     (op_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst;
    logic wr;
    logic rd;
    logic chk_stb;  // compare strobes before the edge (not on reset rows)
    logic ewr;
    logic erd;
    int   cnt;      // expected after the edge
    int   waddr;
    int   raddr;
    int   op;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic w, input logic d,
                              input logic c, input logic ew, input logic er,
                              input int cn, input int wa, input int ra, input int op);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = d; v.chk_stb = c; v.ewr = ew; v.erd = er;
    v.cnt = cn; v.waddr = wa; v.raddr = ra; v.op = op;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Post-edge checks; flag expectations follow from the expected count.
  task automatic chk_state(input int idx, input int cn, input int wa, input int ra, input int op);
    string t;
    t = $sformatf("[%0d]", idx);
    chk({"count", t}, int'(count), cn);
    chk({"fifo_empty", t}, int'(fifo_empty), (cn == 0) ? 1 : 0);
    chk({"fifo_full", t}, int'(fifo_full), (cn == 8) ? 1 : 0);
    chk({"almost_full", t}, int'(almost_full), (cn >= 6) ? 1 : 0);
    chk({"almost_empty", t}, int'(almost_empty), (cn <= 2) ? 1 : 0);
    chk({"wr_addr", t}, int'(wr_addr), wa);
    chk({"rd_addr", t}, int'(rd_addr), ra);
    chk({"op_state", t}, int'(op_state), op);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a concurrent write request: no effect.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, OP_IDLE);
    // Fill: count 1..8 (almost_empty drops at 3, almost_full rises at 6).
    for (int k = 1; k <= 8; k++) add(1, 1, 0, 1, 1, 0, k, k % 8, 0, OP_WRITE);
    // Ninth write rejected.
    add(1, 1, 0, 1, 0, 0, 8, 0, 0, OP_IDLE);
    // Full with both requests: only the read is taken.
    add(1, 1, 1, 1, 0, 1, 7, 0, 1, OP_READ);
    // Drain to empty.
    for (int k = 1; k <= 7; k++) add(1, 0, 1, 1, 0, 1, 7 - k, 0, (1 + k) % 8, OP_READ);
    // Empty with both requests: only the write is taken.
    add(1, 1, 1, 1, 1, 0, 1, 1, 0, OP_WRITE);
    for (int k = 2; k <= 4; k++) add(1, 1, 0, 1, 1, 0, k, k, 0, OP_WRITE);
    // Count 4, 12 simultaneous cycles: both addresses wrap 7->0.
    for (int i = 1; i <= 12; i++) add(1, 1, 1, 1, 1, 1, 4, (4 + i) % 8, i % 8, OP_RDWR);
    add(1, 1, 0, 1, 1, 0, 5, 1, 4, OP_WRITE);
    // Mid-operation reset with a write request discards occupancy.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, OP_IDLE);
    // Read on empty after reset is rejected.
    add(1, 0, 1, 1, 0, 0, 0, 0, 0, OP_IDLE);

    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clock);
      rst = vq[n].rst; wr_req = vq[n].wr; rd_req = vq[n].rd;
      #1;
      if (vq[n].chk_stb) begin
        chk($sformatf("wr_en[%0d]", n), int'(wr_en), int'(vq[n].ewr));
        chk($sformatf("rd_en[%0d]", n), int'(rd_en), int'(vq[n].erd));
      end
      @(posedge clock);
      #1;
      chk_state(n, vq[n].cnt, vq[n].waddr, vq[n].raddr, vq[n].op);
    end

    // Reset held for two edges with both requests, then released idle.
    @(negedge clock); rst = 1'b1; wr_req = 1'b1; rd_req = 1'b0;
    @(posedge clock); #1;
    chk_state(100, 1, 1, 0, OP_WRITE);
    @(negedge clock); rst = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    @(posedge clock); @(negedge clock);
    @(posedge clock); #1;
    chk_state(101, 0, 0, 0, OP_IDLE);
    @(negedge clock); rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    @(posedge clock); #1;
    chk_state(102, 0, 0, 0, OP_IDLE);

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    // Underflow is sticky and a repeat event beats the clear.
    @(negedge clock); rd_req = 1'b1;
    @(posedge clock); #1;
    chk("underflow_set", int'(underflow), 1);
    chk("overflow_quiet", int'(overflow), 0);
    @(negedge clock); err_clr = 1'b1; rd_req = 1'b1;
    @(posedge clock); #1;
    chk("underflow_set_beats_clr", int'(underflow), 1);
    @(negedge clock); err_clr = 1'b1; rd_req = 1'b0;
    @(posedge clock); #1;
    chk("underflow_cleared", int'(underflow), 0);
    @(negedge clock); err_clr = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_param.md
FIFO_CTRL_PARAM -- requirements
Module: fifo_ctrl_param

Interface
REQ-001 Parameter ADDR_W, default 3, address width; depth DEPTH = 2**ADDR_W (default 8).
REQ-002 Parameter AF_TH, default 6, almost-full threshold in entries, legal range 1..DEPTH.
REQ-003 Parameter AE_TH, default 2, almost-empty threshold in entries, legal range 0..DEPTH-1.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 wr_req  in  1  write request, sampled each rising edge.
REQ-007 rd_req  in  1  read request, sampled each rising edge.
REQ-008 wr_en  out  1  write accepted this cycle (storage write strobe).
REQ-009 rd_en  out  1  read accepted this cycle (storage read strobe).
REQ-010 wr_addr  out  ADDR_W  storage write address (low bits of write pointer).
REQ-011 rd_addr  out  ADDR_W  storage read address (low bits of read pointer).
REQ-012 count  out  ADDR_W+1  occupancy, 0..DEPTH.
REQ-013 fifo_full, fifo_empty, almost_full, almost_empty  out  1 each  status flags.
REQ-014 op_state  out  2  last-cycle operation: 0 IDLE, 1 WRITE, 2 READ, 3 RDWR.

Function
REQ-015 Internal write and read pointers SHALL be ADDR_W+1 bits; MSB is the wrap bit; both increment modulo 2**(ADDR_W+1).
REQ-016 fifo_empty SHALL be 1 iff pointers are equal; fifo_full SHALL be 1 iff MSBs differ and low ADDR_W bits are equal; both derived from registered pointers only.
REQ-017 wr_en SHALL be combinational: wr_req AND NOT fifo_full; rd_en SHALL be rd_req AND NOT fifo_empty.
REQ-018 An accepted write SHALL increment the write pointer on the same edge; wr_addr during the accepting cycle is the slot written.
REQ-019 An accepted read SHALL increment the read pointer on the same edge; rd_addr during the accepting cycle is the slot read.
REQ-020 Simultaneous wr_req and rd_req when neither full nor empty: both accepted, count unchanged.
REQ-021 When full: write rejected even if a read is accepted in the same cycle; count decrements by 1.
REQ-022 When empty: read rejected even if a write is accepted in the same cycle; count increments by 1.
REQ-023 count SHALL be registered: +1 write-only, -1 read-only, unchanged for both-or-neither; count SHALL always equal write pointer minus read pointer modulo 2**(ADDR_W+1).
REQ-024 almost_full SHALL be count >= AF_TH; almost_empty SHALL be count <= AE_TH; both combinational from count.
REQ-025 op_state SHALL be a registered FSM updated every edge from the accepted pair (wr_en, rd_en): (0,0)->IDLE, (1,0)->WRITE, (0,1)->READ, (1,1)->RDWR; any state may go to any state.
REQ-026 Pointer wrap from DEPTH-1 to 0 in low bits SHALL toggle the wrap bit with no loss of occupancy.

Reset
REQ-027 On a rising edge with rst=0: pointers 0, count 0, op_state IDLE; hence fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, wr_addr=rd_addr=0.
REQ-028 Reset SHALL override any concurrent request; requests during reset have no effect and are not counted as errors.
REQ-029 Reset asserted mid-operation SHALL discard all occupancy in one edge.

Configuration
REQ-030 Macro FIFO_CTRL_ERR_FLAGS_EN, when defined, SHALL add input err_clr (1) and sticky outputs overflow (1), underflow (1).
REQ-031 With macro: overflow set on edge where wr_req=1 and fifo_full=1; underflow set on edge where rd_req=1 and fifo_empty=1; err_clr=1 clears both; set has priority over clear in the same cycle; reset clears both.
REQ-032 Without macro: err_clr, overflow, underflow ports SHALL not exist; all other behaviour identical.

Verification (ADDR_W=3, AF_TH=6, AE_TH=2)
REQ-033 Reset then 8 write-only cycles -> count 0..8, almost_empty drops at count 3, almost_full rises at count 6, fifo_full=1 after 8th; 9th wr_req gives wr_en=0.
REQ-034 From full, wr_req=rd_req=1 one cycle -> rd_en=1, wr_en=0, count 7, op_state READ.
REQ-035 From empty, wr_req=rd_req=1 one cycle -> wr_en=1, rd_en=0, count 1, op_state WRITE.
REQ-036 Count 4, 12 cycles of simultaneous rd/wr -> count stays 4, both addresses wrap 7->0, wrap bits toggle, op_state RDWR.
REQ-037 Count 5, rst=0 for one edge with wr_req=1 -> count 0, fifo_empty=1, op_state IDLE.
REQ-038 With FIFO_CTRL_ERR_FLAGS_EN: rd_req on empty -> underflow=1 and holds; err_clr with rd_req still on empty -> stays 1; err_clr alone -> 0.
